fpu_rr_arbiter: RTL and testbench

Shares one combinational FP add/sub unit (FPU_unit-style: op select, two 32-bit operands, 32-bit result, overflow/underflow flags) between NUM_REQ requesters.
- Round-robin arbitration grants one requester at a time.
- Operands are registered and driven to the shared unit for one execute cycle.
- Result, flags and requester ID are captured into a response register held under valid/ready back-pressure.
- Sits between the issue logic of the FP clients and the shared FPU datapath.

---
 rtl/fpu_rr_arbiter.sv | 173 +++++++++++++++++
 tb/tb_fpu_rr_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_rr_arbiter.sv
// Round-robin arbiter sharing one combinational FP add/sub unit among NUM_REQ clients.
// Optional sticky overflow/underflow flags are enabled by defining FPU_RR_ARBITER_STICKY_FLAGS_EN.
module fpu_rr_arbiter #(
   parameter  int NUM_REQ = 4,
   parameter  int NUM_OP  = 1,
   localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic [NUM_REQ-1:0]     i_req_valid,
   output logic [NUM_REQ-1:0]     o_req_ready,
   input  logic [NUM_REQ*NUM_OP-1:0] i_req_add_sub,
   input  logic [NUM_REQ*32-1:0]  i_req_a,
   input  logic [NUM_REQ*32-1:0]  i_req_b,
   output logic [NUM_OP-1:0]      o_fpu_add_sub,
   output logic [31:0]            o_fpu_a,
   output logic [31:0]            o_fpu_b,
   input  logic [31:0]            i_fpu_s,
   input  logic                   i_fpu_ov_flag,
   input  logic                   i_fpu_un_flag,
   output logic                   o_rsp_valid,
   input  logic                   i_rsp_ready,
   output logic [ID_W-1:0]        o_rsp_id,
   output logic [31:0]            o_rsp_s,
   output logic                   o_rsp_ov,
   output logic                   o_rsp_un,
`ifdef FPU_RR_ARBITER_STICKY_FLAGS_EN
   input  logic                   i_flag_clr,
   output logic                   o_sticky_ov,
   output logic                   o_sticky_un,
`endif
   output logic                   o_busy
);

   typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

   state_t              state_r, state_nxt_s;
   logic [ID_W-1:0]     ptr_r, id_r, win_idx_s;
   logic                win_found_s, grant_ok_s, req_hs_s, rsp_hs_s;
   logic [NUM_OP-1:0]   sel_op_s, fpu_op_r;
   logic [31:0]         sel_a_s, sel_b_s, fpu_a_r, fpu_b_r, rsp_s_r;
   logic                rsp_valid_r, rsp_ov_r, rsp_un_r;
   logic [ID_W-1:0]     rsp_id_r;

   // Round-robin search starting one past the last winner, wrapping modulo NUM_REQ
   always_comb begin
      int              idx_v;
      logic [ID_W-1:0] cand_v;
      logic            hit_v;
      win_found_s = 1'b0;
      win_idx_s   = '0;
      idx_v       = 0;
      cand_v      = '0;
      hit_v       = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx_v       = (int'(ptr_r) + k) % NUM_REQ;
         cand_v      = ID_W'(idx_v);
         hit_v       = !win_found_s && i_req_valid[cand_v];
         win_idx_s   = hit_v ? cand_v : win_idx_s;
         win_found_s = win_found_s | hit_v;
      end
   end

   // Operand mux selecting the winner's op and operands
   always_comb begin
      logic sel_v;
      sel_op_s = '0;
      sel_a_s  = 32'h0000_0000;
      sel_b_s  = 32'h0000_0000;
      sel_v    = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         sel_v    = (win_idx_s == ID_W'(k));
         sel_op_s = sel_v ? i_req_add_sub[NUM_OP*k +: NUM_OP] : sel_op_s;
         sel_a_s  = sel_v ? i_req_a[32*k +: 32] : sel_a_s;
         sel_b_s  = sel_v ? i_req_b[32*k +: 32] : sel_b_s;
      end
   end

   // Grant is offered from IDLE, or from RESP in the cycle the response is consumed
   assign rsp_hs_s    = (state_r == RESP) && rsp_valid_r && i_rsp_ready;
   assign grant_ok_s  = i_rst_n && ((state_r == IDLE) || rsp_hs_s);
   assign req_hs_s    = grant_ok_s && win_found_s;
   assign o_req_ready = req_hs_s ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx_s) : '0;

   // Next-state logic
   always_comb begin
      state_nxt_s = IDLE;
      case (state_r)
         IDLE:    state_nxt_s = req_hs_s ? EXEC : IDLE;
         EXEC:    state_nxt_s = RESP;
         RESP: begin
            if (rsp_hs_s) begin
               state_nxt_s = req_hs_s ? EXEC : IDLE;
            end else begin
               state_nxt_s = RESP;
            end
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // State register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state_r <= IDLE;
      else          state_r <= state_nxt_s;
   end

   // Operand, pointer and response registers
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ptr_r       <= ID_W'(NUM_REQ - 1);
         id_r        <= '0;
         fpu_op_r    <= '0;
         fpu_a_r     <= 32'h0000_0000;
         fpu_b_r     <= 32'h0000_0000;
         rsp_valid_r <= 1'b0;
         rsp_id_r    <= '0;
         rsp_s_r     <= 32'h0000_0000;
         rsp_ov_r    <= 1'b0;
         rsp_un_r    <= 1'b0;
      end else begin
         if (req_hs_s) begin
            fpu_op_r <= sel_op_s;
            fpu_a_r  <= sel_a_s;
            fpu_b_r  <= sel_b_s;
            id_r     <= win_idx_s;
            ptr_r    <= win_idx_s;
         end else begin
            ptr_r    <= ptr_r;
         end
         if (state_r == EXEC) begin
            rsp_valid_r <= 1'b1;
            rsp_id_r    <= id_r;
            rsp_s_r     <= i_fpu_s;
            rsp_ov_r    <= i_fpu_ov_flag;
            rsp_un_r    <= i_fpu_un_flag;
         end else if (rsp_hs_s || (state_r != RESP)) begin
            rsp_valid_r <= 1'b0;
         end else begin
            rsp_valid_r <= rsp_valid_r;
         end
      end
   end

`ifdef FPU_RR_ARBITER_STICKY_FLAGS_EN
   logic sticky_ov_r, sticky_un_r;

   // Sticky flags: a capture in EXEC sets, clear acts only on bits not being set
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sticky_ov_r <= 1'b0;
         sticky_un_r <= 1'b0;
      end else begin
         sticky_ov_r <= (sticky_ov_r & ~i_flag_clr) | ((state_r == EXEC) & i_fpu_ov_flag);
         sticky_un_r <= (sticky_un_r & ~i_flag_clr) | ((state_r == EXEC) & i_fpu_un_flag);
      end
   end

   assign o_sticky_ov = sticky_ov_r;
   assign o_sticky_un = sticky_un_r;
`endif

   assign o_fpu_add_sub = fpu_op_r;
   assign o_fpu_a       = fpu_a_r;
   assign o_fpu_b       = fpu_b_r;
   assign o_rsp_valid   = rsp_valid_r;
   assign o_rsp_id      = rsp_id_r;
   assign o_rsp_s       = rsp_s_r;
   assign o_rsp_ov      = rsp_ov_r;
   assign o_rsp_un      = rsp_un_r;
   assign o_busy        = (state_r != IDLE);

endmodule

// File: tb/tb_fpu_rr_arbiter.sv
// Bench for fpu_rr_arbiter: directed vector table, sticky-flag sequence, and random traffic
// checked against a transaction-level model with an attached behavioural FP add/sub unit.
module tb_fpu_rr_arbiter;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [3:0]   req_valid, req_ready, req_add_sub;
   logic [127:0] req_a, req_b;
   logic [0:0]   fpu_op;
   logic [31:0]  fpu_a, fpu_b, fpu_s, rsp_s;
   logic         fpu_ov, fpu_un, rsp_valid, rsp_ov, rsp_un, busy;
   logic         rsp_ready = 1'b1;
   logic [1:0]   rsp_id;
   logic         flag_clr = 1'b0;
   logic         sticky_ov, sticky_un;

   logic [3:0]   req_v = 4'd0;
   logic         req_op[4];
   logic [31:0]  req_a_arr[4], req_b_arr[4];

   int n_err = 0, n_chk = 0;

   always #5 clk = ~clk;

   fpu_rr_arbiter #(.NUM_REQ(4), .NUM_OP(1)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_add_sub(req_add_sub),
      .i_req_a(req_a), .i_req_b(req_b),
      .o_fpu_add_sub(fpu_op), .o_fpu_a(fpu_a), .o_fpu_b(fpu_b),
      .i_fpu_s(fpu_s), .i_fpu_ov_flag(fpu_ov), .i_fpu_un_flag(fpu_un),
      .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_id(rsp_id),
      .o_rsp_s(rsp_s), .o_rsp_ov(rsp_ov), .o_rsp_un(rsp_un),
`ifdef FPU_RR_ARBITER_STICKY_FLAGS_EN
      .i_flag_clr(flag_clr), .o_sticky_ov(sticky_ov), .o_sticky_un(sticky_un),
`endif
      .o_busy(busy)
   );

`ifndef FPU_RR_ARBITER_STICKY_FLAGS_EN
   assign sticky_ov = 1'b0;
   assign sticky_un = 1'b0;
`endif

   always_comb begin
      req_valid   = req_v;
      req_add_sub = 4'd0;
      req_a       = 128'd0;
      req_b       = 128'd0;
      for (int k = 0; k < 4; k++) begin
         req_add_sub[k]    = req_op[k];
         req_a[32*k +: 32] = req_a_arr[k];
         req_b[32*k +: 32] = req_b_arr[k];
      end
   end

   // Behavioural single-precision add/sub (denormals flush to zero, truncating rounding)
   function automatic real to_real(input logic [31:0] a);
      logic [63:0] d;
      if (a[30:23] == 8'd0) return 0.0;
      d = {a[31], 11'(32'(a[30:23]) + 32'd896), a[22:0], 29'd0};
      return $bitstoreal(d);
   endfunction

   function automatic logic [33:0] fpu_model(input logic op, input logic [31:0] a, input logic [31:0] b);
      real r;
      logic [63:0] d;
      int ev;
      logic [31:0] s;
      logic ov, un;
      r  = op ? (to_real(a) - to_real(b)) : (to_real(a) + to_real(b));
      ov = 1'b0; un = 1'b0; s = 32'd0;
      if (r != 0.0) begin
         d  = $realtobits(r);
         ev = int'(d[62:52]) - 1023;
         if (ev > 127)       begin ov = 1'b1; s = {d[63], 8'hFF, 23'd0}; end
         else if (ev < -126) begin un = 1'b1; s = {d[63], 31'd0}; end
         else                s = {d[63], 8'(ev + 127), d[51:29]};
      end
      return {ov, un, s};
   endfunction

   assign {fpu_ov, fpu_un, fpu_s} = fpu_model(fpu_op[0], fpu_a, fpu_b);

   // Transaction-level reference model
   int          m_ptr;
   logic        m_exec, m_rsp_valid, m_ov, m_un, m_st_ov, m_st_un, m_op;
   int          m_job, m_rsp_id, m_w;
   logic [31:0] m_a, m_b, m_rsp_s;
   logic [3:0]  m_er, m_granted;

   function automatic void model_reset();
      m_ptr = 3; m_exec = 1'b0; m_rsp_valid = 1'b0; m_ov = 1'b0; m_un = 1'b0;
      m_st_ov = 1'b0; m_st_un = 1'b0; m_op = 1'b0; m_job = 0; m_rsp_id = 0;
      m_a = 32'd0; m_b = 32'd0; m_rsp_s = 32'd0; m_granted = 4'd0;
   endfunction

   function automatic int winner();
      for (int o = 1; o <= 4; o++) begin
         int i = (m_ptr + o) % 4;
         if (req_v[i]) return i;
      end
      return -1;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      n_chk++;
      if (act !== exp_v) begin
         n_err++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp_v);
      end
   endtask

   // Called just after inputs were driven on a falling edge
   task automatic drive_check(input logic rst);
      if (rst) begin rst_n = 1'b0; model_reset(); end
      else rst_n = 1'b1;
      m_w  = winner();
      m_er = (!rst && !m_exec && (!m_rsp_valid || rsp_ready) && m_w >= 0) ? 4'(1 << m_w) : 4'd0;
      #2;
      chk("ready", 32'(req_ready), 32'(m_er));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_rsp_valid));
      chk("busy", 32'(busy), 32'(m_exec || m_rsp_valid));
      chk("fpu_a", fpu_a, m_a);
      chk("fpu_b", fpu_b, m_b);
      chk("fpu_op", 32'(fpu_op), 32'(m_op));
      if (m_rsp_valid) begin
         chk("rsp_id", 32'(rsp_id), 32'(m_rsp_id));
         chk("rsp_s", rsp_s, m_rsp_s);
         chk("rsp_flags", 32'({rsp_ov, rsp_un}), 32'({m_ov, m_un}));
      end
`ifdef FPU_RR_ARBITER_STICKY_FLAGS_EN
      chk("sticky", 32'({sticky_ov, sticky_un}), 32'({m_st_ov, m_st_un}));
`endif
   endtask

   task automatic advance();
      logic [33:0] res;
      @(posedge clk);
      if (!rst_n) return;
      m_granted = 4'd0;
      if (m_exec) begin
         res         = fpu_model(m_op, m_a, m_b);
         m_rsp_valid = 1'b1;
         m_rsp_id    = m_job;
         m_rsp_s     = res[31:0];
         m_ov        = res[33];
         m_un        = res[32];
         m_st_ov     = (m_st_ov & ~flag_clr) | res[33];
         m_st_un     = (m_st_un & ~flag_clr) | res[32];
         m_exec      = 1'b0;
      end else begin
         if (flag_clr) begin m_st_ov = 1'b0; m_st_un = 1'b0; end
         if (m_rsp_valid && rsp_ready) m_rsp_valid = 1'b0;
      end
      if (m_er != 4'd0) begin
         m_exec = 1'b1; m_job = m_w; m_ptr = m_w; m_granted[m_w] = 1'b1;
         m_a = req_a_arr[m_w]; m_b = req_b_arr[m_w]; m_op = req_op[m_w];
      end
   endtask

   function automatic logic [31:0] rnd_fp();
      case ($urandom % 8)
         0:       return 32'h7F7F_FFFF;
         1:       return {1'($urandom), 8'($urandom_range(1, 3)), 23'($urandom)};
         default: return {1'($urandom), 8'($urandom_range(110, 140)), 23'($urandom)};
      endcase
   endfunction

   typedef struct {
      logic rst; logic [3:0] v; logic rdy; logic [3:0] ready; logic rv; logic [1:0] id; logic busy;
   } vec_t;
   vec_t tbl[$];

   function automatic void add(logic rst, logic [3:0] v, logic rdy, logic [3:0] ready,
                               logic rv, logic [1:0] id, logic bsy);
      tbl.push_back('{rst, v, rdy, ready, rv, id, bsy});
   endfunction

   task automatic sticky_step(input logic [3:0] v, input logic clr);
      @(negedge clk);
      req_v = v; flag_clr = clr; rsp_ready = 1'b1;
      drive_check(1'b0);
      advance();
   endtask

   initial begin
      model_reset();
      for (int k = 0; k < 4; k++) begin
         req_op[k] = 1'b0; req_a_arr[k] = 32'h3F80_0000; req_b_arr[k] = 32'h4000_0000;
      end
      // single request, round-robin over all / over {1,3}, back-pressure, reset mid-EXEC
      add(1,4'b0000,1,4'b0000,0,0,0); add(0,4'b0100,1,4'b0100,0,0,0);
      add(0,4'b0000,1,4'b0000,0,0,1); add(0,4'b0000,1,4'b0000,1,2,1);
      add(0,4'b0000,1,4'b0000,0,0,0);
      add(1,4'b1111,1,4'b0000,0,0,0); add(0,4'b1111,1,4'b0001,0,0,0);
      add(0,4'b1111,1,4'b0000,0,0,1); add(0,4'b1111,1,4'b0010,1,0,1);
      add(0,4'b1111,1,4'b0000,0,0,1); add(0,4'b1111,1,4'b0100,1,1,1);
      add(0,4'b1111,1,4'b0000,0,0,1); add(0,4'b1111,1,4'b1000,1,2,1);
      add(0,4'b1111,1,4'b0000,0,0,1); add(0,4'b1111,1,4'b0001,1,3,1);
      add(0,4'b1010,1,4'b0000,0,0,1); add(0,4'b1010,1,4'b0010,1,0,1);
      add(0,4'b1010,1,4'b0000,0,0,1); add(0,4'b1010,1,4'b1000,1,1,1);
      add(0,4'b1010,1,4'b0000,0,0,1); add(0,4'b1010,1,4'b0010,1,3,1);
      add(0,4'b1010,1,4'b0000,0,0,1); add(0,4'b1010,1,4'b1000,1,1,1);
      add(0,4'b0000,1,4'b0000,0,0,1); add(0,4'b0000,1,4'b0000,1,3,1);
      add(0,4'b0000,1,4'b0000,0,0,0);
      add(0,4'b0010,0,4'b0010,0,0,0); add(0,4'b0010,0,4'b0000,0,0,1);
      for (int i = 0; i < 5; i++) add(0,4'b0010,0,4'b0000,1,1,1);
      add(0,4'b0010,1,4'b0010,1,1,1); add(0,4'b0000,1,4'b0000,0,0,1);
      add(0,4'b0000,1,4'b0000,1,1,1); add(0,4'b0000,1,4'b0000,0,0,0);
      add(0,4'b0100,1,4'b0100,0,0,0); add(1,4'b1111,1,4'b0000,0,0,0);
      add(0,4'b1111,1,4'b0001,0,0,0); add(0,4'b0000,1,4'b0000,0,0,1);
      add(0,4'b0000,1,4'b0000,1,0,1); add(0,4'b0000,1,4'b0000,0,0,0);

      foreach (tbl[i]) begin
         @(negedge clk);
         req_v = tbl[i].v; rsp_ready = tbl[i].rdy; flag_clr = 1'b0;
         drive_check(tbl[i].rst);
         chk("t_ready", 32'(req_ready), 32'(tbl[i].ready));
         chk("t_rsp_valid", 32'(rsp_valid), 32'(tbl[i].rv));
         chk("t_busy", 32'(busy), 32'(tbl[i].busy));
         if (tbl[i].rv) begin
            chk("t_rsp_id", 32'(rsp_id), 32'(tbl[i].id));
            chk("t_rsp_s", rsp_s, 32'h4040_0000);
         end
         advance();
      end

`ifdef FPU_RR_ARBITER_STICKY_FLAGS_EN
      @(negedge clk); req_v = 4'd0; drive_check(1'b1); advance();
      req_a_arr[0] = 32'h7F7F_FFFF; req_b_arr[0] = 32'h7F7F_FFFF;
      sticky_step(4'b0001, 1'b0); sticky_step(4'b0000, 1'b0); sticky_step(4'b0000, 1'b0);
      #2 chk("sticky_set", 32'(sticky_ov), 32'd1);
      req_a_arr[0] = 32'h3F80_0000; req_b_arr[0] = 32'h3F80_0000;
      sticky_step(4'b0001, 1'b0); sticky_step(4'b0000, 1'b0); sticky_step(4'b0000, 1'b0);
      #2 chk("sticky_hold", 32'(sticky_ov), 32'd1);
      sticky_step(4'b0000, 1'b1);
      #2 chk("sticky_clr", 32'(sticky_ov), 32'd0);
      req_a_arr[0] = 32'h7F7F_FFFF; req_b_arr[0] = 32'h7F7F_FFFF;
      sticky_step(4'b0001, 1'b0); sticky_step(4'b0000, 1'b1);
      #2 chk("sticky_set_wins", 32'(sticky_ov), 32'd1);
      sticky_step(4'b0000, 1'b0);
`endif

      // Random traffic; requesters hold until granted, occasionally withdraw
      for (int n = 0; n < 1500; n++) begin
         @(negedge clk);
         for (int k = 0; k < 4; k++) begin
            if (m_granted[k]) req_v[k] = 1'b0;
            else if (req_v[k] && ($urandom % 16 == 0)) req_v[k] = 1'b0;
            else if (!req_v[k] && ($urandom % 3 == 0)) begin
               req_v[k] = 1'b1; req_op[k] = 1'($urandom);
               req_a_arr[k] = rnd_fp(); req_b_arr[k] = rnd_fp();
            end
         end
         rsp_ready = ($urandom % 4) != 0;
         flag_clr  = ($urandom % 16) == 0;
         drive_check(1'b0);
         advance();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
